// File: rtl/dmem_ctrl_pkg.sv
// Shared types and default geometry for the data-memory access controller.
// Owner/tag definitions are used by the arbiter and the return pipeline.
package dmem_ctrl_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_STARVE_LIMIT = 3;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_load;
  } tag_t;

endpackage

// File: rtl/dmem_fair_arbiter.sv
// Two-way CPU/loader arbiter, combinational grant; no backpressure beyond withholding gnt.
// DMEM_ARB_FAIR_EN adds a starvation counter that forces the loader through; otherwise strict CPU priority.
module dmem_fair_arbiter
  import dmem_ctrl_pkg::*;
`ifdef DMEM_ARB_FAIR_EN
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
)
`endif
(
`ifdef DMEM_ARB_FAIR_EN
  input  logic   clk,
`endif
  input  logic   rst_n,
  input  logic   cpu_req,
  input  logic   ldr_req,
  output logic   cpu_gnt,
  output logic   ldr_gnt,
  output owner_e win_owner
);

`ifdef DMEM_ARB_FAIR_EN
  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  logic [1:0] starve_cnt;
  logic       contested;
  logic       ldr_turn;

  assign contested = cpu_req & ldr_req;
  assign ldr_turn  = contested & (starve_cnt == LIMIT);
  assign cpu_gnt   = rst_n & cpu_req & ~ldr_turn;
  assign ldr_gnt   = rst_n & ldr_req & (~cpu_req | ldr_turn);

  // Only contested CPU wins count toward starvation; any loader win resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 2'd0;
    end else if (ldr_gnt) begin
      starve_cnt <= 2'd0;
    end else if (contested) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end
`else
  assign cpu_gnt = rst_n & cpu_req;
  assign ldr_gnt = rst_n & ldr_req & ~cpu_req;
`endif

  assign win_owner = ldr_gnt ? OWN_LDR : OWN_CPU;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares the data-memory port between CPU and loader; access registered 1 cycle, load data returns 2 cycles after grant.
// Backpressure is via combinational gnt only; optional fair arbitration under DMEM_ARB_FAIR_EN.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] data_rd_addr,
  output logic [ADDR_W-1:0] data_wr_addr,
  output logic [DATA_W-1:0] datamem_wr_data,
  output logic              store_to_mem,
  input  logic [DATA_W-1:0] datamem_rd_data
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 3)) begin : g_limit_chk
    $error("STARVE_LIMIT must fit the 2-bit starvation counter (1..3)");
  end

  localparam logic [ADDR_W-1:0] ADDR_LSB = ADDR_W'(1);

  owner_e            win_owner;
  logic              any_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  tag_t              tag_q;

  dmem_fair_arbiter
`ifdef DMEM_ARB_FAIR_EN
    #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
  u_arb (
`ifdef DMEM_ARB_FAIR_EN
    .clk       (clk),
`endif
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .ldr_req   (ldr_req),
    .cpu_gnt   (cpu_gnt),
    .ldr_gnt   (ldr_gnt),
    .win_owner (win_owner)
  );

  assign any_gnt   = cpu_gnt | ldr_gnt;
  assign win_we    = (win_owner == OWN_LDR) ? ldr_we    : cpu_we;
  assign win_addr  = (win_owner == OWN_LDR) ? ldr_addr  : cpu_addr;
  assign win_wdata = (win_owner == OWN_LDR) ? ldr_wdata : cpu_wdata;

  // A store parks the read port; if it is parked on the write address, nudge it off by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_to_mem    <= 1'b0;
      data_rd_addr    <= '0;
      data_wr_addr    <= '0;
      datamem_wr_data <= '0;
    end else begin
      store_to_mem <= any_gnt & win_we;
      if (any_gnt) begin
        if (win_we) begin
          data_wr_addr    <= win_addr;
          datamem_wr_data <= win_wdata;
          if (data_rd_addr == win_addr) begin
            data_rd_addr <= win_addr ^ ADDR_LSB;
          end
        end else begin
          data_rd_addr <= win_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q.valid   <= any_gnt;
      tag_q.owner   <= win_owner;
      tag_q.is_load <= ~win_we;
    end
  end

  // Second stage: capture read data and steer it to its owner; the other side holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      cpu_rvalid <= tag_q.valid & tag_q.is_load & (tag_q.owner == OWN_CPU);
      ldr_rvalid <= tag_q.valid & tag_q.is_load & (tag_q.owner == OWN_LDR);
      if (tag_q.valid && tag_q.is_load) begin
        if (tag_q.owner == OWN_CPU) begin
          cpu_rdata <= datamem_rd_data;
        end else begin
          ldr_rdata <= datamem_rd_data;
        end
      end
    end
  end

endmodule
